// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the byte-stream instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CKSUM_W        = 8;

  localparam int LEN_W  = HDR_BYTES * 8;
  localparam int WORD_W = BYTES_PER_WORD * 8;
  localparam int IDX_W  = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes LSB-first into a word and flags each completed word for one cycle.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [IDX_W-1:0]  byte_idx,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              word_valid_q, word_valid_d;

  always_comb begin
    shift_d      = shift_q;
    idx_d        = idx_q;
    word_valid_d = 1'b0;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid) begin
      // Newest byte enters at the top so the first byte ends up in bits [7:0].
      shift_d      = {byte_data, shift_q[WORD_W-1:8]};
      idx_d        = idx_q + 1'b1;
      word_valid_d = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      idx_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign byte_idx   = idx_q;
  assign word_valid = word_valid_q;
  assign word_data  = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image, writes it to instruction memory and holds the CPU
// in reset until the whole image has arrived with a matching checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_W);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CKSUM_W-1:0] sum_q, sum_d;
  logic [ADDR_W-1:0]  widx_q, widx_d;

  logic              accept;
  logic              start_ok;
  logic              last_word;
  logic [LEN_W-1:0]  hdr_len;
  logic [IDX_W-1:0]  byte_idx;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;

  assign busy      = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CKSUM);
  assign rx_ready  = busy;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_reset = !done;

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && !busy;
  assign hdr_len   = {rx_data, len_q[7:0]};
  // widx_q already holds the index of the word being completed: the previous word's
  // write retires at least three cycles before this word's last byte can arrive.
  assign last_word = (32'(widx_q) == 32'(len_q) - 32'd1);

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (accept && (state_q == S_DATA)),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  assign mem_we    = word_valid;
  assign mem_addr  = widx_q;
  assign mem_wdata = DATA_W'(word_data);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    widx_d  = widx_q;
    if (word_valid) begin
      widx_d = widx_q + 1'b1;
    end
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_LO;
          sum_d   = '0;
          widx_d  = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = hdr_len;
          if ((hdr_len == '0) || (32'(hdr_len) > MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d = sum_q + rx_data;
          if ((byte_idx == IDX_W'(BYTES_PER_WORD - 1)) && last_word) begin
            state_d = S_CKSUM;
          end
        end
      end
      S_CKSUM: begin
        if (accept) begin
          state_d = (rx_data == sum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      widx_q  <= widx_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed and random frames, expected writes queued at
// stimulus time and checked by an independent write monitor.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Write monitor: every mem_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%08h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=0x%08h, required addr=%0d data=0x%08h",
                   mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int gap;
    gap = (gap_mode >= 0) ? gap_mode : int'($urandom_range(3, 0));
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (rx_ready) begin
        tick();
        rx_valid = 1'b0;
        return;
      end
      tick();
    end
    rx_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles, required 1");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_error"},     32'(error),     32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs({tag, "_abort"});
    chk({tag, "_abort_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Reference model: header gives N, each 4 data bytes form one LE word at consecutive
  // addresses, and the trailing byte must equal the data-byte sum mod 256.
  task automatic run_frame(input bq_t f, input int gap_mode, input int start_at,
                           input int abort_at, input string tag);
    int         n;
    logic [7:0] sum;
    bit         ok;
    wr_t        w;
    n = int'({f[1], f[0]});
    pulse_start();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    send_byte(f[0], gap_mode);
    send_byte(f[1], gap_mode);
    if (n == 0 || n > 2 ** ADDR_W) begin
      chk({tag, "_error"},     32'(error),     32'd1);
      chk({tag, "_done"},      32'(done),      32'd0);
      chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      chk({tag, "_busy_end"},  32'(busy),      32'd0);
      chk({tag, "_pending"},   32'(exp_q.size()), 32'd0);
      return;
    end
    sum = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      if (i == abort_at) begin
        do_reset(tag);
        return;
      end
      if (i == start_at) pulse_start();
      if (i % 4 == 3) begin
        w.addr = ADDR_W'(i / 4);
        w.data = {f[2+i], f[1+i], f[i], f[i-1]};
        exp_q.push_back(w);
      end
      sum = sum + f[2+i];
      send_byte(f[2+i], gap_mode);
    end
    ok = (sum == f[2+4*n]);
    send_byte(f[2+4*n], gap_mode);
    chk({tag, "_done"},      32'(done),      32'(ok));
    chk({tag, "_error"},     32'(error),     32'(!ok));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
    chk({tag, "_busy_end"},  32'(busy),      32'd0);
    chk({tag, "_pending"},   32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bq_t        f1, f2, f2bad, f;
    int         n;
    logic [7:0] s;

    f1    = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    f2    = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h07};
    f2bad = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h08};

    #3;
    check_reset_outputs("por");
    tick();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("idle_rx_ready",  32'(rx_ready),  32'd0);
      chk("idle_done",      32'(done),      32'd0);
      chk("idle_error",     32'(error),     32'd0);
    end

    run_frame(f1, 0, -1, -1, "one_word");
    run_frame(f2, 0, -1, -1, "two_word");
    run_frame(f2, 3, -1, -1, "two_word_gaps");
    run_frame(f2bad, 0, -1, -1, "bad_cksum");
    run_frame(f2, 0, -1, -1, "recover");

    f = '{8'h00, 8'h00};
    run_frame(f, 0, -1, -1, "len_zero");
    f = '{8'h01, 8'h04};
    run_frame(f, 0, -1, -1, "len_1025");

    run_frame(f1, 0, -1, 2, "mid_reset");
    run_frame(f1, 0, -1, -1, "after_reset");
    run_frame(f2, 0, 5, -1, "start_in_data");

    for (int r = 0; r < 12; r++) begin
      f.delete();
      n = int'($urandom_range(6, 1));
      f.push_back(8'(n));
      f.push_back(8'h00);
      s = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        f.push_back(8'($urandom_range(255, 0)));
        s = s + f[2+i];
      end
      if ($urandom_range(3, 0) == 0) s = s ^ 8'($urandom_range(255, 1));
      f.push_back(s);
      run_frame(f, -1, ($urandom_range(2, 0) == 0) ? int'($urandom_range(4 * n - 1, 0)) : -1,
                -1, $sformatf("rand%0d", r));
    end

    f.delete();
    f.push_back(8'h00);
    f.push_back(8'h04);
    s = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      f.push_back(8'($urandom_range(255, 0)));
      s = s + f[2+i];
    end
    f.push_back(s);
    run_frame(f, 0, -1, -1, "len_1024");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
